regfile_8x8: RTL and testbench
==============================

Name: regfile_8x8

Overview:
- Operand register file that sits directly upstream of the 8-bit logical/ALU stage.
- Holds eight 8-bit registers and drives that stage's A and B operand buses from two independent read ports.
- Result written back through one synchronous write port.
- R0 is hardwired to zero. Optional same-cycle write-to-read bypass.

Parameters:
- WIDTH, 8, data width of each register and of every data port.
- DEPTH, 8, number of registers; address width is log2(DEPTH) = 3.
- BYPASS, 1, when 1 a write forwards to a matching read port in the same cycle; when 0 reads return the pre-write value.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- WE  input  1  write enable.
- WA  input  3  write address.
- WD  input  WIDTH  write data.
- RA1  input  3  read address, port 1 (feeds operand A).
- RA2  input  3  read address, port 2 (feeds operand B).
- RD1  output  WIDTH  read data, port 1.
- RD2  output  WIDTH  read data, port 2.

Behaviour:
- Reset:
  - RST high asynchronously clears registers R1..R7 to 8'h00, independent of CLK.
  - While RST is high, RD1 = RD2 = 8'h00 regardless of addresses, WE or bypass.
  - Writes are ignored while RST is high. The first write can take effect on the first rising edge after RST deasserts.
- Write:
  - On rising CLK with RST low and WE=1, R[WA] <= WD.
  - WE=0 leaves all registers unchanged.
- R0:
  - A write with WA=0 is discarded.
  - R0 always reads 8'h00, including under bypass.
- Read timing:
  - Reads are combinational, with zero-cycle latency from RA1/RA2 to RD1/RD2.
  - Read ports are independent; RA1 == RA2 returns the same value on both.
- Bypass (BYPASS=1):
  - If WE=1, WA!=0 and RAx==WA, then RDx = WD in the same cycle, before the edge.
  - Applies to both ports simultaneously when both match.
- Bypass disabled (BYPASS=0): RDx shows the stored value until the edge, then the new value.
- Write-after-write: one write per cycle; the last edge wins.
- Address range:
  - All 3-bit addresses are valid; there is no out-of-range case at DEPTH=8.
  - If DEPTH<8, writes to addresses >= DEPTH are discarded and reads of them return 0.
- Reset mid-operation: RST asserting in the same cycle as WE=1 discards the write; the register stays 0.
- X handling: no X may propagate to RD1/RD2 from unwritten registers after reset.

Test Plan:
1. Reset: hold RST=1 with WE=1, WA=3, WD=8'hAA across 2 edges, then release -> RD1/RD2 = 8'h00 for all RA1/RA2; R3 reads 8'h00 after release.
2. Basic write/read: write R1=8'h0F, R2=8'hF0 on successive edges, then RA1=1, RA2=2 -> RD1=8'h0F, RD2=8'hF0; downstream OR gives 8'hFF, AND gives 8'h00.
3. R0 immutability: WE=1, WA=0, WD=8'h5A, RA1=0 -> RD1=8'h00 before and after the edge, also with BYPASS=1.
4. Bypass: R4 holds 8'h11; drive WE=1, WA=4, WD=8'h22, RA1=RA2=4:
   - BYPASS=1 -> RD1=RD2=8'h22 before the edge.
   - BYPASS=0 -> 8'h11 before the edge, 8'h22 after.
5. Async reset mid-stream: R5=8'h77, assert RST between clock edges -> RD (RA1=5) drops to 8'h00 immediately without a clock edge; it stays 8'h00 after release until R5 is rewritten.
6. Full sweep: write R[i] = 8'h10*i for i=1..7, then read every pair (RA1, RA2) over 0..7 -> each RD equals the expected value (R0 = 0); WE=0 cycles interleaved change nothing.

Source files
------------

// File: rtl/regfile_8x8.sv
// Operand register file for the 8-bit ALU stage: two combinational read ports,
// one synchronous write port, R0 hardwired to zero, optional write-to-read bypass.
module regfile_8x8 #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 8,
    parameter bit          BYPASS = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WE,
    input  logic [2:0]       WA,
    input  logic [WIDTH-1:0] WD,
    input  logic [2:0]       RA1,
    input  logic [2:0]       RA2,
    output logic [WIDTH-1:0] RD1,
    output logic [WIDTH-1:0] RD2
);

    localparam int unsigned AW      = 3;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    // R0 has no storage; only R1..DEPTH-1 are flops (DEPTH is 2..8)
    logic [WIDTH-1:0] reg_q [1:DEPTH-1];
    logic [WIDTH-1:0] reg_d [1:DEPTH-1];

    logic             wr_valid_c;
    logic [AW-1:0]    ra_c [2];
    logic [WIDTH-1:0] rd_c [2];

    // A write lands only on an implemented, non-zero register
    always_comb begin : wr_qualify
        wr_valid_c = WE && (WA != '0) && ({1'b0, WA} < DEPTH_W);
    end

    always_comb begin : write_next
        for (int unsigned i = 1; i < DEPTH; i++) begin
            reg_d[i] = reg_q[i];
            if (wr_valid_c && (WA == AW'(i))) begin
                reg_d[i] = WD;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin : reg_state
        if (RST) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                reg_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                reg_q[i] <= reg_d[i];
            end
        end
    end

    always_comb begin : ra_pack
        ra_c[0] = RA1;
        ra_c[1] = RA2;
    end

    // Read mux: unmatched addresses (R0, beyond DEPTH) fall through to zero;
    // reset forces zero over everything, including the bypass path
    always_comb begin : read_ports
        for (int p = 0; p < 2; p++) begin
            rd_c[p] = '0;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (ra_c[p] == AW'(i)) begin
                    rd_c[p] = reg_q[i];
                end
            end
            if (BYPASS && wr_valid_c && (WA == ra_c[p])) begin
                rd_c[p] = WD;
            end
            if (RST) begin
                rd_c[p] = '0;
            end
        end
    end

    assign RD1 = rd_c[0];
    assign RD2 = rd_c[1];

endmodule

// File: tb/tb_regfile_8x8.sv
// Directed bench for regfile_8x8: bypass, non-bypass and DEPTH=4 instances
// share one stimulus stream; every expected value is hand-computed here.
module tb_regfile_8x8;

    logic       clk;
    logic       rst;
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] ra1;
    logic [2:0] ra2;
    logic [7:0] rd1_byp, rd2_byp;
    logic [7:0] rd1_nob, rd2_nob;
    logic [7:0] rd1_d4,  rd2_d4;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [7:0] exp_mem [8];
    logic [7:0] e1, e2, e1_d4, e2_d4;

    regfile_8x8 #(.WIDTH(8), .DEPTH(8), .BYPASS(1'b1)) dut_byp (
        .CLK(clk), .RST(rst), .WE(we), .WA(wa), .WD(wd),
        .RA1(ra1), .RA2(ra2), .RD1(rd1_byp), .RD2(rd2_byp)
    );

    regfile_8x8 #(.WIDTH(8), .DEPTH(8), .BYPASS(1'b0)) dut_nob (
        .CLK(clk), .RST(rst), .WE(we), .WA(wa), .WD(wd),
        .RA1(ra1), .RA2(ra2), .RD1(rd1_nob), .RD2(rd2_nob)
    );

    regfile_8x8 #(.WIDTH(8), .DEPTH(4), .BYPASS(1'b1)) dut_d4 (
        .CLK(clk), .RST(rst), .WE(we), .WA(wa), .WD(wd),
        .RA1(ra1), .RA2(ra2), .RD1(rd1_d4), .RD2(rd2_d4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, expv);
        end
    endtask

    // One write cycle; inputs change 1 time unit after the edge
    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        we = 1'b1;
        wa = a;
        wd = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        // Test 1: reset held with a write pending across two edges
        rst = 1'b1; we = 1'b1; wa = 3'd3; wd = 8'hAA; ra1 = 3'd3; ra2 = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        for (int a = 0; a < 8; a++) begin
            ra1 = 3'(a);
            ra2 = 3'(7 - a);
            #1;
            check("rst_rd1_byp", rd1_byp, 8'h00);
            check("rst_rd2_byp", rd2_byp, 8'h00);
            check("rst_rd1_nob", rd1_nob, 8'h00);
        end
        @(negedge clk);
        we = 1'b0; rst = 1'b0; ra1 = 3'd3; ra2 = 3'd3;
        @(posedge clk);
        #1;
        check("post_rst_r3_byp", rd1_byp, 8'h00);
        check("post_rst_r3_nob", rd2_nob, 8'h00);

        // Test 2: basic write/read feeding the logic stage
        wr(3'd1, 8'h0F);
        wr(3'd2, 8'hF0);
        ra1 = 3'd1; ra2 = 3'd2;
        #1;
        check("rd1_r1", rd1_byp, 8'h0F);
        check("rd2_r2", rd2_byp, 8'hF0);
        check("or_ab",  rd1_nob | rd2_nob, 8'hFF);
        check("and_ab", rd1_nob & rd2_nob, 8'h00);

        // Test 3: R0 stays zero, bypass included
        ra1 = 3'd0; we = 1'b1; wa = 3'd0; wd = 8'h5A;
        #1;
        check("r0_pre_byp", rd1_byp, 8'h00);
        check("r0_pre_nob", rd1_nob, 8'h00);
        @(posedge clk);
        #1;
        check("r0_post_byp", rd1_byp, 8'h00);
        check("r0_post_nob", rd1_nob, 8'h00);
        we = 1'b0;

        // Test 4: bypass versus stored value on both ports
        wr(3'd4, 8'h11);
        ra1 = 3'd4; ra2 = 3'd4; we = 1'b1; wa = 3'd4; wd = 8'h22;
        #1;
        check("byp_rd1_pre", rd1_byp, 8'h22);
        check("byp_rd2_pre", rd2_byp, 8'h22);
        check("nob_rd1_pre", rd1_nob, 8'h11);
        check("nob_rd2_pre", rd2_nob, 8'h11);
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        check("nob_rd1_post", rd1_nob, 8'h22);
        check("nob_rd2_post", rd2_nob, 8'h22);
        check("byp_rd1_post", rd1_byp, 8'h22);

        // Test 5: asynchronous reset between edges
        wr(3'd5, 8'h77);
        ra1 = 3'd5;
        #1;
        check("r5_before_rst", rd1_byp, 8'h77);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("r5_async_rst_byp", rd1_byp, 8'h00);
        check("r5_async_rst_nob", rd1_nob, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("r5_after_release", rd1_nob, 8'h00);
        wr(3'd5, 8'h77);
        check("r5_rewritten", rd1_nob, 8'h77);

        // Test 6: full sweep with idle cycles interleaved
        exp_mem[0] = 8'h00;
        for (int i = 1; i < 8; i++) begin
            exp_mem[i] = 8'(8'h10 * i);
            wr(3'(i), exp_mem[i]);
        end
        for (int a = 0; a < 8; a++) begin
            we = 1'b0;
            wa = 3'($urandom_range(0, 7));
            wd = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
            for (int b = 0; b < 8; b++) begin
                ra1 = 3'(a);
                ra2 = 3'(b);
                #1;
                e1    = exp_mem[a];
                e2    = exp_mem[b];
                e1_d4 = (a < 4) ? exp_mem[a] : 8'h00;
                e2_d4 = (b < 4) ? exp_mem[b] : 8'h00;
                check("sweep_rd1_byp", rd1_byp, e1);
                check("sweep_rd2_byp", rd2_byp, e2);
                check("sweep_rd1_nob", rd1_nob, e1);
                check("sweep_rd2_nob", rd2_nob, e2);
                check("sweep_rd1_d4",  rd1_d4,  e1_d4);
                check("sweep_rd2_d4",  rd2_d4,  e2_d4);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
